// File: rtl/usb_turnaround_ctrl.sv
// USB full-speed bus turnaround controller: enforces the inter-packet gap before TX
// and times out a missing handshake. Optional timeout statistics: USB_TURNAROUND_STATS_EN.
module usb_turnaround_ctrl #(
  parameter int IPD_MIN_BITS      = 2,
  parameter int RESP_TIMEOUT_BITS = 16
) (
  input  logic       clk48_i,
  input  logic       rst_i,
  input  logic       rxEop_i,
  input  logic       rxActive_i,
  input  logic       txReq_i,
  input  logic       expectResponse_i,
  input  logic       txEop_i,
  output logic       txGrant_o,
  output logic       waitingResponse_o,
  output logic       rxTimeout_o,
  output logic [7:0] timeoutCount_o
);

  localparam int MAX_BITS = (IPD_MIN_BITS > RESP_TIMEOUT_BITS) ? IPD_MIN_BITS : RESP_TIMEOUT_BITS;
  localparam int CNT_W    = ($clog2(4 * MAX_BITS) < 1) ? 1 : $clog2(4 * MAX_BITS);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(4 * IPD_MIN_BITS - 1);
  localparam logic [CNT_W-1:0] RESP_LAST = CNT_W'(4 * RESP_TIMEOUT_BITS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RX_GAP    = 3'd1,
    TX_BUSY   = 3'd2,
    WAIT_RESP = 3'd3,
    TIMEOUT   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tx_grant_q, waiting_q, timeout_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (rxEop_i) begin
          state_d = RX_GAP;
          cnt_d   = '0;
        end else if (txReq_i) begin
          state_d = TX_BUSY;
        end
      end
      RX_GAP: begin
        // A new EOP restarts the gap even if it lands on the terminal count.
        if (rxEop_i) begin
          cnt_d = '0;
        end else if (cnt_q == GAP_LAST) begin
          state_d = txReq_i ? TX_BUSY : IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      TX_BUSY: begin
        if (txEop_i) begin
          if (expectResponse_i) begin
            state_d = WAIT_RESP;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      WAIT_RESP: begin
        // Bus activity wins over the terminal count: a late response is not a timeout.
        if (rxActive_i) begin
          state_d = IDLE;
        end else if (cnt_q == RESP_LAST) begin
          state_d = TIMEOUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      TIMEOUT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are flopped from the next state so they line up with state_q.
  always_ff @(posedge clk48_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      tx_grant_q <= 1'b0;
      waiting_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_grant_q <= (state_d == TX_BUSY);
      waiting_q  <= (state_d == WAIT_RESP);
      timeout_q  <= (state_d == TIMEOUT);
    end
  end

  assign txGrant_o         = tx_grant_q;
  assign waitingResponse_o = waiting_q;
  assign rxTimeout_o       = timeout_q;

`ifdef USB_TURNAROUND_STATS_EN
  logic [7:0] tcount_q, tcount_d;

  always_comb begin
    tcount_d = tcount_q;
    if (state_q == TIMEOUT && tcount_q != 8'hFF) begin
      tcount_d = tcount_q + 8'd1;
    end
  end

  always_ff @(posedge clk48_i) begin
    if (rst_i) begin
      tcount_q <= 8'h00;
    end else begin
      tcount_q <= tcount_d;
    end
  end

  assign timeoutCount_o = tcount_q;
`else
  assign timeoutCount_o = 8'h00;
`endif

endmodule

// File: tb/tb_usb_turnaround_ctrl.sv
// Scoreboard bench for usb_turnaround_ctrl: a timestamp-based reference model predicts
// every cycle's outputs; a negedge monitor compares. Directed timing checks are added.
module tb_usb_turnaround_ctrl;

  localparam int IPD = 2;
  localparam int RTO = 16;
`ifdef USB_TURNAROUND_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk48 = 1'b0;
  logic       rst = 1'b1;
  logic       rx_eop = 1'b0, rx_active = 1'b0, tx_req = 1'b0, expect_resp = 1'b0, tx_eop = 1'b0;
  logic       tx_grant, waiting, rx_timeout;
  logic [7:0] tcount;

  usb_turnaround_ctrl #(.IPD_MIN_BITS(IPD), .RESP_TIMEOUT_BITS(RTO)) dut (
    .clk48_i(clk48), .rst_i(rst), .rxEop_i(rx_eop), .rxActive_i(rx_active),
    .txReq_i(tx_req), .expectResponse_i(expect_resp), .txEop_i(tx_eop),
    .txGrant_o(tx_grant), .waitingResponse_o(waiting), .rxTimeout_o(rx_timeout),
    .timeoutCount_o(tcount)
  );

  always #5 clk48 = ~clk48;

  typedef struct packed { logic g; logic w; logic t; logic [7:0] c; } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model: bus phase plus the cycle index at which the phase began.
  typedef enum int { P_IDLE, P_GAP, P_TX, P_WAIT, P_TO } phase_t;
  phase_t phase = P_IDLE;
  int     since = 0;
  int     cyc = 0;
  int     m_count = 0;

  task automatic model(input bit e, a, r, x, t, rs);
    phase_t prev = phase;
    if (rs) begin
      phase = P_IDLE;
      m_count = 0;
    end else begin
      case (prev)
        P_IDLE: if (e) begin phase = P_GAP; since = cyc + 1; end
                else if (r) phase = P_TX;
        P_GAP:  if (e) since = cyc + 1;
                else if (cyc - since == 4 * IPD - 1) phase = r ? P_TX : P_IDLE;
        P_TX:   if (t) begin
                  if (x) begin phase = P_WAIT; since = cyc + 1; end
                  else phase = P_IDLE;
                end
        P_WAIT: if (a) phase = P_IDLE;
                else if (cyc - since == 4 * RTO - 1) phase = P_TO;
        P_TO:   phase = P_IDLE;
        default: phase = P_IDLE;
      endcase
      if (prev == P_TO && STATS && m_count < 255) m_count++;
    end
  endtask

  task automatic step(input bit e, a, r, x, t);
    exp_t ex;
    rx_eop = e; rx_active = a; tx_req = r; expect_resp = x; tx_eop = t;
    @(posedge clk48);
    #1;
    model(e, a, r, x, t, rst);
    cyc++;
    ex.g = (phase == P_TX);
    ex.w = (phase == P_WAIT);
    ex.t = (phase == P_TO);
    ex.c = 8'(m_count);
    exp_q.push_back(ex);
  endtask

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  // Monitor: the DUT presents outputs every cycle; compare against the queued prediction.
  initial begin
    exp_t ex;
    forever begin
      @(negedge clk48);
      if (exp_q.size() > 0) begin
        ex = exp_q.pop_front();
        checks++;
        if ({tx_grant, waiting, rx_timeout, tcount} !== ex) begin
          errors++;
          $display("FAIL scoreboard cycle %0d got g%b w%b t%b c%0d want g%b w%b t%b c%0d",
                   cyc, tx_grant, waiting, rx_timeout, tcount, ex.g, ex.w, ex.t, ex.c);
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    step(0, 0, 0, 0, 0);
    rst = 1'b0;
  endtask

  // Handshake wait: act_at = offset of rxActive pulse after txEop, 0 for none.
  task automatic resp_scn(input int act_at, input string nm);
    int lim = (act_at != 0) ? act_at : 64;
    do_reset();
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 1);
    for (int k = 1; k <= 66; k++) begin
      chk({nm, "_waiting"}, waiting, (k <= lim) ? 1 : 0);
      chk({nm, "_timeout"}, rx_timeout, (act_at == 0 && k == 65) ? 1 : 0);
      step(0, (k == act_at) ? 1'b1 : 1'b0, 0, 0, 0);
    end
  endtask

  // Gap: rxEop at T with txReq held; optional second rxEop at T+second.
  task automatic gap_scn(input int second, input string nm);
    int first = (second != 0) ? second + 9 : 9;
    do_reset();
    step(1, 0, 1, 0, 0);
    for (int k = 1; k <= 18; k++) begin
      chk({nm, "_grant"}, tx_grant, (k >= first) ? 1 : 0);
      step((k == second) ? 1'b1 : 1'b0, 0, 1, 0, 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("reset_grant", tx_grant, 0);
    chk("reset_count", tcount, 0);
    rst = 1'b0;

    resp_scn(0, "timeout");
    chk("count_after_timeout", tcount, STATS ? 1 : 0);
    resp_scn(30, "response");
    resp_scn(64, "race");
    gap_scn(0, "gap");
    gap_scn(5, "gap_restart");

    // No handshake expected: straight back to IDLE.
    do_reset();
    step(0, 0, 1, 0, 0);
    chk("nohs_grant", tx_grant, 1);
    step(0, 0, 0, 0, 1);
    for (int k = 1; k <= 4; k++) begin
      chk("nohs_grant_off", tx_grant, 0);
      chk("nohs_waiting", waiting, 0);
      step(0, 0, 0, 0, 0);
    end

    // Reset in the middle of a response wait.
    do_reset();
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 1);
    for (int k = 1; k < 20; k++) step(0, 0, 0, 0, 0);
    chk("midwait_waiting", waiting, 1);
    rst = 1'b1;
    step(0, 0, 1, 0, 0);
    rst = 1'b0;
    chk("midwait_rst_out", {tx_grant, waiting, rx_timeout, tcount}, 0);

`ifdef USB_TURNAROUND_STATS_EN
    do_reset();
    for (int i = 0; i < 300; i++) begin
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 1);
      repeat (66) step(0, 0, 0, 0, 0);
    end
    chk("stats_saturate", tcount, 255);
`endif

    // Randomized traffic, checked only by the scoreboard.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0) rst = 1'b1;
      step($urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0);
      rst = 1'b0;
    end

    step(0, 0, 0, 0, 0);
    @(negedge clk48);
    @(negedge clk48);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
